// File: rtl/nibble_serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sub_pkg
// Brief    : Shared types and constants for the nibble-serial subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package sub_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nibs(input int width);
        return width / NIB_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_subtractor_if
// Brief    : Start/done handshake and operand/result bus; SUB_OVF_EN adds ovf.
// Revision : 1.0 - initial release
// ============================================================================
interface nibble_serial_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, bin,
                    input  busy, done, diff, bout, ovf);
    modport slave  (input  start, a, b, bin,
                    output busy, done, diff, bout, ovf);
`else
    modport master (output start, a, b, bin,
                    input  busy, done, diff, bout);
    modport slave  (input  start, a, b, bin,
                    output busy, done, diff, bout);
`endif
endinterface
`default_nettype wire

// File: rtl/nibble_serial_subtractor_nibble_sub.sv
`default_nettype none
// ============================================================================
// Module   : nibble_sub
// Brief    : Combinational 4-bit borrow-lookahead subtractor, d = x - y - bi.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_sub
    import sub_pkg::*;
(
    input  logic [NIB_W-1:0] x,
    input  logic [NIB_W-1:0] y,
    input  logic             bi,
    output logic [NIB_W-1:0] d,
    output logic             bo
);

    // A bit generates a borrow when x=0,y=1 and passes one through when x==y.
    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] p;
    logic [NIB_W:0]   brw;

    assign g = ~x & y;
    assign p = ~(x ^ y);

    assign brw[0] = bi;
    assign brw[1] = g[0] | (p[0] & bi);
    assign brw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
    assign brw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & bi);
    assign brw[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & bi);

    assign d  = x ^ y ^ brw[NIB_W-1:0];
    assign bo = brw[NIB_W];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_subtractor
// Brief    : WIDTH-bit a - b - bin, one nibble per clock, LSB nibble first.
//            Define SUB_OVF_EN to add the signed-overflow output ovf.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic                       clk,
    input  logic                       rst_n,
    nibble_serial_subtractor_if.slave  bus
);

    localparam int NIBS  = calc_nibs(WIDTH);
    localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;

    generate
        if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
            $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [NIB_W-1:0] nib_x;
    logic [NIB_W-1:0] nib_y;
    logic [NIB_W-1:0] nib_d;
    logic             nib_bo;
    logic             last_nib;

    always_comb begin
        nib_x = '0;
        nib_y = '0;
        for (int i = 0; i < NIBS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_x = a_q[i*NIB_W +: NIB_W];
                nib_y = b_q[i*NIB_W +: NIB_W];
            end
        end
    end

    assign last_nib = (idx_q == IDX_W'(NIBS - 1));

    nibble_sub u_nib (
        .x  (nib_x),
        .y  (nib_y),
        .bi (brw_q),
        .d  (nib_d),
        .bo (nib_bo)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        idx_d   = idx_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        busy_d  = busy_q;
        done_d  = done_q;
`ifdef SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    brw_d   = bus.bin;
                    diff_d  = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NIBS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        diff_d[i*NIB_W +: NIB_W] = nib_d;
                    end
                end
                brw_d = nib_bo;
                idx_d = idx_q + IDX_W'(1);
                if (last_nib) begin
                    idx_d   = '0;
                    bout_d  = nib_bo;
                    done_d  = 1'b1;
                    state_d = DONE;
`ifdef SUB_OVF_EN
                    // Final nibble's MSB is the result sign bit.
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (nib_d[NIB_W-1] != a_q[WIDTH-1]);
`endif
                end
            end
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            idx_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            idx_q   <= idx_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_subtractor
// Brief    : Self-checking bench: vector table, scoreboard queue, corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_subtractor;

    localparam int WIDTH = 16;
    localparam int NIBS  = WIDTH / 4;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             bin;
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
    } exp_t;

    logic clk;
    logic rst_n;

    int   vectors     = 0;
    int   miscompares = 0;
    int   done_count  = 0;
    int   pushed      = 0;
    logic [WIDTH-1:0] last_exp_diff = '0;

    exp_t exp_q[$];
    vec_t vecs[10];

    nibble_serial_subtractor_if #(.WIDTH(WIDTH)) bus_if ();

    nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic bin);
        exp_t        e;
        logic [WIDTH:0] r;
        r      = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
        e.diff = r[WIDTH-1:0];
        e.bout = r[WIDTH];
        e.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding op.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus_if.done) begin
            done_count++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: done=1 with no pending operation");
            end else begin
                e = exp_q.pop_front();
                check("diff", 32'(bus_if.diff), 32'(e.diff));
                check("bout", 32'(bus_if.bout), 32'(e.bout));
`ifdef SUB_OVF_EN
                check("ovf",  32'(bus_if.ovf),  32'(e.ovf));
`endif
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic bin, input exp_t e, input bit track);
        int n;
        n = 0;
        while (bus_if.busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("idle_timeout", 32'(bus_if.busy), 32'd0);
        bus_if.start = 1'b1;
        bus_if.a     = a;
        bus_if.b     = b;
        bus_if.bin   = bin;
        if (track) begin
            exp_q.push_back(e);
            pushed++;
            last_exp_diff = e.diff;
        end
        @(negedge clk);
        bus_if.start = 1'b0;
        check("busy_after_accept", 32'(bus_if.busy), 32'd1);
    endtask

    task automatic wait_done(input int exp_lat);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus_if.done !== 1'b1 && cyc < 20);
        check("latency", 32'(cyc), 32'(exp_lat));
        @(negedge clk);
        check("busy_after_done", 32'(bus_if.busy), 32'd0);
        check("done_one_cycle", 32'(bus_if.done), 32'd0);
        check("diff_hold", 32'(bus_if.diff), 32'(last_exp_diff));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   dc0;
        logic [WIDTH-1:0] ra, rb;
        logic             rbin;

        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[2] = '{16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[3] = '{16'h00F0, 16'h00F0, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        vecs[6] = '{16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[8] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[9] = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1};

        rst_n        = 1'b0;
        bus_if.start = 1'b0;
        bus_if.a     = '0;
        bus_if.b     = '0;
        bus_if.bin   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_done", 32'(bus_if.done), 32'd0);
        check("rst_diff", 32'(bus_if.diff), 32'd0);
        check("rst_bout", 32'(bus_if.bout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            e.diff = vecs[i].diff;
            e.bout = vecs[i].bout;
            e.ovf  = vecs[i].ovf;
            start_op(vecs[i].a, vecs[i].b, vecs[i].bin, e, 1'b1);
            wait_done(NIBS);
        end

        // start during RUN is ignored; operands are already latched
        dc0 = done_count;
        start_op(16'h9000, 16'h1000, 1'b0, model(16'h9000, 16'h1000, 1'b0), 1'b1);
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.a     = 16'h0001;
        bus_if.b     = 16'h0001;
        bus_if.bin   = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        wait_done(NIBS - 2);
        e.diff = 16'h0000; e.bout = 1'b0; e.ovf = 1'b0;
        start_op(16'h0001, 16'h0001, 1'b0, e, 1'b1);
        wait_done(NIBS);
        check("done_pulses", 32'(done_count - dc0), 32'd2);

        // reset mid-RUN discards the operation
        start_op(16'h5555, 16'h1111, 1'b0, e, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus_if.busy), 32'd0);
        check("midrst_done", 32'(bus_if.done), 32'd0);
        check("midrst_diff", 32'(bus_if.diff), 32'd0);
        check("midrst_bout", 32'(bus_if.bout), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        e.diff = 16'hA000; e.bout = 1'b0; e.ovf = 1'b0;
        start_op(16'hABCD, 16'h0BCD, 1'b0, e, 1'b1);
        wait_done(NIBS);

        for (int i = 0; i < 16; i++) begin
            ra   = WIDTH'($urandom);
            rb   = WIDTH'($urandom);
            rbin = 1'($urandom_range(1, 0));
            start_op(ra, rb, rbin, model(ra, rb, rbin), 1'b1);
            wait_done(NIBS);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("done_total", 32'(done_count), 32'(pushed));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
